// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle control sequencer: takes instructions from fetch, decodes them and
// walks DECODE/EXEC/MEM/WB, driving register-bank, ALU, data-memory and PC controls.
module unidade_controle_multiciclo #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        mem_done,
    input  logic        Zero,
    output logic [5:0]  RS,
    output logic [5:0]  RT,
    output logic [5:0]  RD,
    output logic [31:0] imediato,
    output logic [3:0]  ALUOp,
    output logic        ALUSrc,
    output logic        SumZero,
    output logic        ULAData,
    output logic        RegWrite,
    output logic        NOP,
    output logic        StackOP,
    output logic        JAL,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        PCWrite,
    output logic [1:0]  PCSrc,
    output logic        illegal,
    output logic        mem_timeout,
    output logic [2:0]  dbg_state
);

    // Handshake: an instruction transfers at a rising edge where instr_valid and
    // instr_ready are both high; instr_ready is high only in FETCH.

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef struct packed {
        logic [5:0]  rs;
        logic [5:0]  rt;
        logic [5:0]  rd;
        logic [31:0] imm;
        logic [3:0]  aluop;
        logic        alusrc;
        logic        sumzero;
        logic        uladata;
        logic        stackop;
        logic        jal;
        logic        nop;
        logic        illegal;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jump;
        logic        to_wb;
    } dec_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h01;
    localparam logic [5:0] OP_LW   = 6'h02;
    localparam logic [5:0] OP_SW   = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h05;
    localparam logic [5:0] OP_JAL  = 6'h06;
    localparam logic [5:0] OP_PUSH = 6'h07;
    localparam logic [5:0] OP_POP  = 6'h08;
    localparam logic [5:0] OP_LI   = 6'h09;
    localparam logic [5:0] OP_MOVE = 6'h0A;
    localparam logic [5:0] OP_NOP  = 6'h3F;

    localparam logic [15:0] LP_MEM_LAST = 16'(MEM_TIMEOUT - 1);

    function automatic dec_t f_decode(input logic [31:0] ins);
        dec_t d;
        d       = '0;
        d.rs    = ins[25:20];
        d.rt    = ins[19:14];
        d.rd    = ins[13:8];
        d.imm   = {{18{ins[13]}}, ins[13:0]};
        case (ins[31:26])
            OP_R: begin
                d.aluop = ins[3:0];
                d.to_wb = 1'b1;
            end
            OP_ADDI: begin
                d.alusrc = 1'b1;
                d.rd     = ins[19:14];
                d.to_wb  = 1'b1;
            end
            OP_LW: begin
                d.alusrc  = 1'b1;
                d.rd      = ins[19:14];
                d.is_load = 1'b1;
            end
            OP_SW: begin
                d.alusrc   = 1'b1;
                d.is_store = 1'b1;
            end
            OP_BEQ: begin
                d.aluop     = 4'b0001;
                d.is_branch = 1'b1;
            end
            OP_J: begin
                d.is_jump = 1'b1;
            end
            OP_JAL: begin
                d.jal   = 1'b1;
                d.to_wb = 1'b1;
            end
            OP_PUSH: begin
                d.stackop  = 1'b1;
                d.is_store = 1'b1;
            end
            OP_POP: begin
                d.stackop = 1'b1;
                d.rd      = ins[19:14];
                d.is_load = 1'b1;
            end
            OP_LI: begin
                d.sumzero = 1'b1;
                d.alusrc  = 1'b1;
                d.rd      = ins[19:14];
                d.to_wb   = 1'b1;
            end
            OP_MOVE: begin
                // MOVE passes dado2 through the ALU as dado2 + 0
                d.uladata = 1'b1;
                d.alusrc  = 1'b1;
                d.imm     = 32'h0;
                d.rd      = ins[19:14];
                d.to_wb   = 1'b1;
            end
            OP_NOP: begin
                d.nop = 1'b1;
            end
            default: begin
                d.nop     = 1'b1;
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

    state_t      r_state;
    logic [31:0] r_ir;
    logic [15:0] r_mem_cnt;
    logic        r_instr_ready;
    logic        r_regwrite;
    logic        r_pcwrite;
    logic [1:0]  r_pcsrc;
    logic        r_memread;
    logic        r_memwrite;
    logic        r_beq_exec;

    dec_t w_dec;
    logic w_active;
    logic w_to_mem;
    logic w_direct;
    logic w_mem_abort;
    logic w_store_done;

    always_comb begin
        w_dec        = f_decode(r_ir);
        w_active     = (r_state != S_FETCH);
        w_to_mem     = w_dec.is_load | w_dec.is_store;
        w_direct     = ~w_dec.to_wb & ~w_to_mem;
        w_mem_abort  = (r_state == S_MEM) && !mem_done && (r_mem_cnt == LP_MEM_LAST);
        w_store_done = (r_state == S_MEM) && mem_done && w_dec.is_store;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_ir          <= 32'h0;
            r_mem_cnt     <= 16'h0;
            r_instr_ready <= 1'b1;
            r_regwrite    <= 1'b0;
            r_pcwrite     <= 1'b0;
            r_pcsrc       <= 2'b00;
            r_memread     <= 1'b0;
            r_memwrite    <= 1'b0;
            r_beq_exec    <= 1'b0;
        end else begin
            r_regwrite <= 1'b0;
            r_pcwrite  <= 1'b0;
            r_pcsrc    <= 2'b00;
            r_beq_exec <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (instr_valid && r_instr_ready) begin
                        r_ir          <= instr;
                        r_instr_ready <= 1'b0;
                        r_state       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_state <= S_EXEC;
                    // Branch/jump/NOP retire from EXEC, so their PC strobe is set up here
                    if (w_direct) begin
                        r_pcwrite  <= 1'b1;
                        r_pcsrc    <= w_dec.is_jump ? 2'b10 : 2'b00;
                        r_beq_exec <= w_dec.is_branch;
                    end
                end
                S_EXEC: begin
                    if (w_dec.to_wb) begin
                        r_state    <= S_WB;
                        r_regwrite <= 1'b1;
                        r_pcwrite  <= 1'b1;
                        r_pcsrc    <= w_dec.jal ? 2'b10 : 2'b00;
                    end else if (w_to_mem) begin
                        r_state    <= S_MEM;
                        r_mem_cnt  <= 16'h0;
                        r_memread  <= w_dec.is_load;
                        r_memwrite <= w_dec.is_store;
                    end else begin
                        r_state       <= S_FETCH;
                        r_instr_ready <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (mem_done) begin
                        r_memread  <= 1'b0;
                        r_memwrite <= 1'b0;
                        if (w_dec.is_load) begin
                            r_state    <= S_WB;
                            r_regwrite <= 1'b1;
                            r_pcwrite  <= 1'b1;
                        end else begin
                            r_state       <= S_FETCH;
                            r_instr_ready <= 1'b1;
                        end
                    end else if (w_mem_abort) begin
                        r_memread     <= 1'b0;
                        r_memwrite    <= 1'b0;
                        r_state       <= S_FETCH;
                        r_instr_ready <= 1'b1;
                    end else begin
                        r_mem_cnt <= 16'(r_mem_cnt + 16'd1);
                    end
                end
                S_WB: begin
                    r_state       <= S_FETCH;
                    r_instr_ready <= 1'b1;
                end
                default: begin
                    r_state       <= S_FETCH;
                    r_instr_ready <= 1'b1;
                end
            endcase
        end
    end

    assign instr_ready = r_instr_ready;
    assign RS          = w_active ? w_dec.rs      : 6'h0;
    assign RT          = w_active ? w_dec.rt      : 6'h0;
    assign RD          = w_active ? w_dec.rd      : 6'h0;
    assign imediato    = w_active ? w_dec.imm     : 32'h0;
    assign ALUOp       = w_active ? w_dec.aluop   : 4'h0;
    assign ALUSrc      = w_active & w_dec.alusrc;
    assign SumZero     = w_active & w_dec.sumzero;
    assign ULAData     = w_active & w_dec.uladata;
    assign StackOP     = w_active & w_dec.stackop;
    assign JAL         = w_active & w_dec.jal;
    assign NOP         = w_active & w_dec.nop;
    assign illegal     = (r_state == S_DECODE) & w_dec.illegal;
    assign RegWrite    = r_regwrite;
    assign MemRead     = r_memread;
    assign MemWrite    = r_memwrite;
    // Zero and mem_done are consumed in the same cycle they are presented
    assign PCWrite     = r_pcwrite | w_store_done;
    assign PCSrc       = (r_beq_exec && Zero) ? 2'b01 : r_pcsrc;
    assign mem_timeout = w_mem_abort;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Bench for unidade_controle_multiciclo: a per-instruction trace model predicts every
// output cycle by cycle; literal expectations pin key cycles of that model.
module tb_unidade_controle_multiciclo;

    localparam int T_MEM = 8;

    typedef struct packed {
        logic        ready;
        logic [5:0]  rs;
        logic [5:0]  rt;
        logic [5:0]  rd;
        logic [31:0] imm;
        logic [3:0]  aluop;
        logic        alusrc;
        logic        sumzero;
        logic        uladata;
        logic        regwrite;
        logic        nop;
        logic        stackop;
        logic        jal;
        logic        memread;
        logic        memwrite;
        logic        pcwrite;
        logic [1:0]  pcsrc;
        logic        illegal;
        logic        mtout;
    } obs_t;

    localparam int W = $bits(obs_t);

    logic        clock;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        mem_done;
    logic        Zero;
    logic [5:0]  RS, RT, RD;
    logic [31:0] imediato;
    logic [3:0]  ALUOp;
    logic        ALUSrc, SumZero, ULAData, RegWrite, NOP, StackOP, JAL;
    logic        MemRead, MemWrite, PCWrite, illegal, mem_timeout;
    logic [1:0]  PCSrc;
    logic [2:0]  dbg_state;

    unidade_controle_multiciclo #(.MEM_TIMEOUT(T_MEM)) dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .mem_done(mem_done), .Zero(Zero),
        .RS(RS), .RT(RT), .RD(RD), .imediato(imediato), .ALUOp(ALUOp),
        .ALUSrc(ALUSrc), .SumZero(SumZero), .ULAData(ULAData), .RegWrite(RegWrite),
        .NOP(NOP), .StackOP(StackOP), .JAL(JAL), .MemRead(MemRead), .MemWrite(MemWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .illegal(illegal), .mem_timeout(mem_timeout),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] act_log[$];
    obs_t         idle_e;

    function automatic obs_t sample();
        obs_t o;
        o.ready = instr_ready; o.rs = RS; o.rt = RT; o.rd = RD; o.imm = imediato;
        o.aluop = ALUOp; o.alusrc = ALUSrc; o.sumzero = SumZero; o.uladata = ULAData;
        o.regwrite = RegWrite; o.nop = NOP; o.stackop = StackOP; o.jal = JAL;
        o.memread = MemRead; o.memwrite = MemWrite; o.pcwrite = PCWrite;
        o.pcsrc = PCSrc; o.illegal = illegal; o.mtout = mem_timeout;
        return o;
    endfunction

    // scoreboard: one expected vector per cycle, checked mid-cycle
    logic [W-1:0] sb_act, sb_exp;
    always @(negedge clock) begin
        cyc++;
        if (exp_q.size() > 0) begin
            sb_act = sample();
            sb_exp = exp_q.pop_front();
            act_log.push_back(sb_act);
            checks++;
            if (sb_act !== sb_exp) begin
                failures++;
                $display("FAIL trace cyc=%0d got=%h want=%h", cyc, sb_act, sb_exp);
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // model of the decoded view of an instruction
    function automatic logic known_op(input logic [5:0] op);
        return (op <= 6'h0A) || (op == 6'h3F);
    endfunction

    function automatic obs_t decoded(input logic [31:0] ins);
        obs_t o;
        logic [5:0] op;
        o  = '0;
        op = ins[31:26];
        o.rs      = ins[25:20];
        o.rt      = ins[19:14];
        o.rd      = (op inside {6'h01, 6'h02, 6'h08, 6'h09, 6'h0A}) ? ins[19:14] : ins[13:8];
        o.imm     = (op == 6'h0A) ? 32'h0 : {{18{ins[13]}}, ins[13:0]};
        o.aluop   = (op == 6'h00) ? ins[3:0] : ((op == 6'h04) ? 4'b0001 : 4'b0000);
        o.alusrc  = op inside {6'h01, 6'h02, 6'h03, 6'h09, 6'h0A};
        o.sumzero = (op == 6'h09);
        o.uladata = (op == 6'h0A);
        o.stackop = op inside {6'h07, 6'h08};
        o.jal     = (op == 6'h06);
        o.nop     = (op == 6'h3F) || !known_op(op);
        return o;
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] rs,
                                       input logic [5:0] rt, input logic [13:0] low);
        return {op, rs, rt, low};
    endfunction

    // driver: present inputs for one cycle and queue that cycle's expected outputs
    task automatic run(input logic v, input logic [31:0] ins, input logic done,
                       input logic z, input obs_t e);
        exp_q.push_back(e);
        instr_valid = v;
        instr       = ins;
        mem_done    = done;
        Zero        = z;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            run(1'b0, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), idle_e);
    endtask

    // one whole instruction: handshake, then each phase the rules prescribe
    task automatic issue(input logic [31:0] ins, input logic z, input int delay,
                         input logic noise);
        obs_t d, e;
        logic [5:0] op;
        logic wb, ld, st;
        op = ins[31:26];
        d  = decoded(ins);
        wb = op inside {6'h00, 6'h01, 6'h06, 6'h09, 6'h0A};
        ld = op inside {6'h02, 6'h08};
        st = op inside {6'h03, 6'h07};
        run(1'b1, ins, 1'b0, noise, idle_e);
        e = d;
        e.illegal = !known_op(op);
        run(noise, 32'hFFFF_FFFF, noise, noise, e);
        e = d;
        if (!wb && !ld && !st) begin
            e.pcwrite = 1'b1;
            e.pcsrc   = (op == 6'h05) ? 2'b10 : ((op == 6'h04 && z) ? 2'b01 : 2'b00);
        end
        run(noise, 32'hFFFF_FFFF, noise, z, e);
        if (ld || st) begin
            e = d;
            e.memread  = ld;
            e.memwrite = st;
            if (delay >= T_MEM) begin
                for (int k = 0; k < T_MEM; k++) begin
                    e.mtout = (k == T_MEM - 1);
                    run(noise, 32'hFFFF_FFFF, 1'b0, noise, e);
                end
            end else begin
                for (int k = 0; k < delay; k++)
                    run(noise, 32'hFFFF_FFFF, 1'b0, noise, e);
                e.pcwrite = st;
                run(noise, 32'hFFFF_FFFF, 1'b1, noise, e);
            end
        end
        if (wb || ld) begin
            e = d;
            e.regwrite = 1'b1;
            e.pcwrite  = 1'b1;
            e.pcsrc    = (op == 6'h06) ? 2'b10 : 2'b00;
            run(noise, 32'hFFFF_FFFF, noise, noise, e);
        end
    endtask

    int   base;
    int   cnt;
    obs_t o;
    obs_t d;
    obs_t e;
    logic [31:0] ins;

    initial begin
        idle_e       = '0;
        idle_e.ready = 1'b1;
        reset        = 1'b1;
        instr_valid  = 1'b0;
        instr        = 32'h0;
        mem_done     = 1'b0;
        Zero         = 1'b0;

        #12;
        chk("reset_state", sample(), idle_e);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(2);

        // ADDI RS=2 RT=5 imm=0x3FFD
        base = act_log.size();
        issue(mk(6'h01, 6'd2, 6'd5, 14'h3FFD), 1'b0, 0, 1'b0);
        o = act_log[base + 1];
        chk("addi_rd", W'(o.rd), W'(5));
        chk("addi_imm", W'(o.imm), W'(32'hFFFF_FFFD));
        chk("addi_alusrc", W'(o.alusrc), W'(1));
        chk("addi_aluop", W'(o.aluop), W'(0));
        o = act_log[base + 3];
        chk("addi_wb_regwrite", W'(o.regwrite), W'(1));
        chk("addi_wb_pcwrite", W'(o.pcwrite), W'(1));
        chk("addi_ready_after", W'(instr_ready), W'(1));

        issue(mk(6'h00, 6'd1, 6'd2, {6'd3, 8'h02}), 1'b0, 0, 1'b1);

        // BEQ taken / not taken
        base = act_log.size();
        issue(mk(6'h04, 6'd7, 6'd8, 14'h0010), 1'b1, 0, 1'b0);
        o = act_log[base + 2];
        chk("beq_taken_pcwrite", W'(o.pcwrite), W'(1));
        chk("beq_taken_pcsrc", W'(o.pcsrc), W'(2'b01));
        base = act_log.size();
        issue(mk(6'h04, 6'd7, 6'd8, 14'h0010), 1'b0, 0, 1'b1);
        o = act_log[base + 2];
        chk("beq_nt_pcsrc", W'(o.pcsrc), W'(2'b00));
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            o = act_log[base + i];
            cnt += int'(o.regwrite);
        end
        chk("beq_no_regwrite", W'(cnt), W'(0));

        // loads and stores
        base = act_log.size();
        issue(mk(6'h02, 6'd3, 6'd9, 14'h0004), 1'b0, 4, 1'b0);
        cnt = 0;
        for (int i = 3; i < 8; i++) begin
            o = act_log[base + i];
            cnt += int'(o.memread);
        end
        chk("lw_memread_cycles", W'(cnt), W'(5));
        o = act_log[base + 8];
        chk("lw_wb_regwrite", W'(o.regwrite), W'(1));
        chk("lw_rd", W'(o.rd), W'(9));
        base = act_log.size();
        issue(mk(6'h07, 6'd30, 6'd4, 14'h0000), 1'b0, 2, 1'b0);
        o = act_log[base + 1];
        chk("push_stackop", W'(o.stackop), W'(1));
        issue(mk(6'h08, 6'd30, 6'd6, 14'h0000), 1'b0, 0, 1'b1);
        issue(mk(6'h03, 6'd1, 6'd2, 14'h2001), 1'b0, 1, 1'b0);
        idle(1);

        // jumps, LI, MOVE, NOP
        issue(mk(6'h05, 6'd0, 6'd0, 14'h0100), 1'b1, 0, 1'b0);
        issue(mk(6'h06, 6'd0, 6'd0, 14'h0200), 1'b0, 0, 1'b1);
        issue(mk(6'h09, 6'd0, 6'd12, 14'h1234), 1'b0, 0, 1'b0);
        issue(mk(6'h0A, 6'd13, 6'd14, 14'h0777), 1'b0, 0, 1'b0);
        issue(mk(6'h3F, 6'd0, 6'd0, 14'h0000), 1'b1, 0, 1'b0);

        // store with no mem_done: abort after T_MEM cycles
        base = act_log.size();
        issue(mk(6'h03, 6'd5, 6'd6, 14'h0008), 1'b0, 1000, 1'b0);
        cnt = 0;
        for (int i = 3; i < 3 + T_MEM; i++) begin
            o = act_log[base + i];
            cnt += int'(o.memwrite);
        end
        chk("sw_to_memwrite_cycles", W'(cnt), W'(T_MEM));
        o = act_log[base + 2 + T_MEM];
        chk("sw_to_pulse", W'(o.mtout), W'(1));
        chk("sw_to_no_pcwrite", W'(o.pcwrite), W'(0));

        // unknown opcode with instr_valid held through DECODE/EXEC
        base = act_log.size();
        issue(mk(6'h2A, 6'd1, 6'd1, 14'h0001), 1'b0, 0, 1'b1);
        o = act_log[base + 1];
        chk("ill_pulse", W'(o.illegal), W'(1));
        chk("ill_nop", W'(o.nop), W'(1));
        o = act_log[base + 2];
        chk("ill_exec_pcwrite", W'(o.pcwrite), W'(1));
        issue(mk(6'h00, 6'd4, 6'd5, {6'd6, 8'h03}), 1'b0, 0, 1'b0);

        // reset in the middle of a load's MEM phase
        ins = mk(6'h02, 6'd2, 6'd3, 14'h0010);
        d   = decoded(ins);
        run(1'b1, ins, 1'b0, 1'b0, idle_e);
        run(1'b0, 32'h0, 1'b0, 1'b0, d);
        run(1'b0, 32'h0, 1'b0, 1'b0, d);
        e = d;
        e.memread = 1'b1;
        run(1'b0, 32'h0, 1'b0, 1'b0, e);
        run(1'b0, 32'h0, 1'b0, 1'b0, e);
        #2;
        chk("rst_pre_memread", W'(MemRead), W'(1));
        reset = 1'b1;
        #1;
        chk("rst_memread_drop", W'(MemRead), W'(0));
        chk("rst_all_outputs", sample(), idle_e);
        @(posedge clock);
        #1;
        reset = 1'b0;
        issue(mk(6'h01, 6'd2, 6'd5, 14'h3FFD), 1'b0, 0, 1'b0);
        idle(2);

        #20;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expectations got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
